// File: rtl/eh2_lsu_quiesce_ctl.sv
// Per-thread LSU quiesce/halt responder: blocks issue, drains, and acknowledges a TLU halt.
// Optional halted-cycle statistics are enabled with `define RV_LSU_QUIESCE_STATS_EN.
module eh2_lsu_quiesce_ctl #(
    parameter int NUM_THREADS  = 2,
    parameter int QUIET_CYCLES = 4,
    parameter int TIMEOUT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic [NUM_THREADS-1:0]    halt_req,
    input  logic [NUM_THREADS-1:0]    force_halt,
    input  logic [NUM_THREADS-1:0]    pipe_busy,
    input  logic [NUM_THREADS-1:0]    lsu_stbuf_empty_any,
    input  logic [NUM_THREADS-1:0]    lsu_bus_buffer_empty_any,
    input  logic [NUM_THREADS-1:0]    lsu_bus_idle_any,
    input  logic [NUM_THREADS-1:0]    lr_vld,
    output logic [NUM_THREADS-1:0]    issue_block,
    output logic [NUM_THREADS-1:0]    halt_ack,
    output logic [NUM_THREADS-1:0]    drain_timeout,
    output logic                      lsu_idle_any,
    output logic [NUM_THREADS*16-1:0] halt_cycles
);

    typedef enum logic [2:0] {
        S_RUN,
        S_BLOCK,
        S_DRAIN,
        S_QUIET,
        S_HALTED
    } state_t;

    localparam int                   QW        = 4;
    localparam logic [QW-1:0]        QUIET_MAX = QW'(QUIET_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TO_MAX    = {TIMEOUT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] TO_PRE    = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t                 r_state   [NUM_THREADS];
    state_t                 w_state_nxt [NUM_THREADS];
    logic [QW-1:0]          r_quiet   [NUM_THREADS];
    logic [QW-1:0]          w_quiet_nxt [NUM_THREADS];
    logic [TIMEOUT_W-1:0]   r_tmo     [NUM_THREADS];
    logic [TIMEOUT_W-1:0]   w_tmo_nxt [NUM_THREADS];
    logic [NUM_THREADS-1:0] w_pulse;
    logic [NUM_THREADS-1:0] w_empty;

    logic [NUM_THREADS-1:0] r_issue_block;
    logic [NUM_THREADS-1:0] r_halt_ack;
    logic [NUM_THREADS-1:0] r_drain_timeout;
    logic                   r_lsu_idle_any;

    assign w_empty = lsu_stbuf_empty_any & lsu_bus_buffer_empty_any &
                     lsu_bus_idle_any & ~pipe_busy;

    // Force beats release; release beats every normal transition.
    always_comb begin
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_quiet_nxt[i] = r_quiet[i];
            w_tmo_nxt[i]   = r_tmo[i];
            w_pulse[i]     = 1'b0;
            if (force_halt[i]) begin
                w_state_nxt[i] = S_HALTED;
                w_quiet_nxt[i] = '0;
                w_tmo_nxt[i]   = '0;
            end else if ((r_state[i] != S_RUN) && !halt_req[i]) begin
                w_state_nxt[i] = S_RUN;
                w_quiet_nxt[i] = '0;
                w_tmo_nxt[i]   = '0;
            end else begin
                case (r_state[i])
                    S_RUN: begin
                        if (halt_req[i]) w_state_nxt[i] = S_BLOCK;
                    end
                    S_BLOCK: begin
                        w_state_nxt[i] = S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (r_tmo[i] != TO_MAX) begin
                            w_tmo_nxt[i] = r_tmo[i] + 1'b1;
                            w_pulse[i]   = (r_tmo[i] == TO_PRE);
                        end
                        if (w_empty[i]) begin
                            w_state_nxt[i] = S_QUIET;
                            w_quiet_nxt[i] = QW'(1);
                        end
                    end
                    S_QUIET: begin
                        if (!w_empty[i]) begin
                            w_state_nxt[i] = S_DRAIN;
                            w_quiet_nxt[i] = '0;
                        end else if (r_quiet[i] == QUIET_MAX) begin
                            w_state_nxt[i] = S_HALTED;
                            w_quiet_nxt[i] = '0;
                            w_tmo_nxt[i]   = '0;
                        end else begin
                            w_quiet_nxt[i] = r_quiet[i] + 1'b1;
                        end
                    end
                    S_HALTED: begin
                        w_state_nxt[i] = S_HALTED;
                    end
                    default: begin
                        w_state_nxt[i] = S_RUN;
                        w_quiet_nxt[i] = '0;
                        w_tmo_nxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                r_state[i] <= S_RUN;
                r_quiet[i] <= '0;
                r_tmo[i]   <= '0;
            end
            r_issue_block   <= '0;
            r_halt_ack      <= '0;
            r_drain_timeout <= '0;
            r_lsu_idle_any  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                r_state[i]         <= w_state_nxt[i];
                r_quiet[i]         <= w_quiet_nxt[i];
                r_tmo[i]           <= w_tmo_nxt[i];
                r_issue_block[i]   <= (w_state_nxt[i] != S_RUN);
                r_halt_ack[i]      <= (w_state_nxt[i] == S_HALTED);
            end
            r_drain_timeout <= w_pulse;
            r_lsu_idle_any  <= &(w_empty & ~lr_vld);
        end
    end

    assign issue_block   = r_issue_block;
    assign halt_ack      = r_halt_ack;
    assign drain_timeout = r_drain_timeout;
    assign lsu_idle_any  = r_lsu_idle_any;

`ifdef RV_LSU_QUIESCE_STATS_EN
    logic [15:0] r_hcnt [NUM_THREADS];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            if (!rst_l) begin
                r_hcnt[i] <= '0;
            end else if ((r_state[i] == S_HALTED) && (r_hcnt[i] != 16'hFFFF)) begin
                r_hcnt[i] <= r_hcnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_stats
        assign halt_cycles[16*g +: 16] = r_hcnt[g];
    end
`else
    assign halt_cycles = '0;
`endif

endmodule

// File: tb/tb_eh2_lsu_quiesce_ctl.sv
// Self-checking bench for eh2_lsu_quiesce_ctl: directed halt scenarios followed by
// randomized traffic, all compared against a counter-based behavioural model.
module tb_eh2_lsu_quiesce_ctl;

    localparam int NT   = 2;
    localparam int QC   = 4;
    localparam int TW   = 4;
    localparam int TMAX = (1 << TW) - 1;

    logic             clk = 1'b0;
    logic             rst_l;
    logic [NT-1:0]    halt_req, force_halt, pipe_busy;
    logic [NT-1:0]    stbuf_empty, bbuf_empty, bus_idle, lr_vld;
    logic [NT-1:0]    issue_block, halt_ack, drain_timeout;
    logic             lsu_idle_any;
    logic [NT*16-1:0] halt_cycles;

    always #5 clk = ~clk;

    eh2_lsu_quiesce_ctl #(
        .NUM_THREADS (NT),
        .QUIET_CYCLES(QC),
        .TIMEOUT_W   (TW)
    ) dut (
        .clk                     (clk),
        .rst_l                   (rst_l),
        .halt_req                (halt_req),
        .force_halt              (force_halt),
        .pipe_busy               (pipe_busy),
        .lsu_stbuf_empty_any     (stbuf_empty),
        .lsu_bus_buffer_empty_any(bbuf_empty),
        .lsu_bus_idle_any        (bus_idle),
        .lr_vld                  (lr_vld),
        .issue_block             (issue_block),
        .halt_ack                (halt_ack),
        .drain_timeout           (drain_timeout),
        .lsu_idle_any            (lsu_idle_any),
        .halt_cycles             (halt_cycles)
    );

    int checks = 0;
    int errors = 0;

    // Model: a thread is "engaged" from halt acceptance until release; the first
    // engaged cycle is the block cycle, then an empty-streak counter drives the halt.
    bit m_engaged [NT];
    bit m_blockcyc[NT];
    bit m_halted  [NT];
    int m_streak  [NT];
    int m_tmo     [NT];
    bit m_pulse   [NT];
    int m_hcnt    [NT];
    bit m_idle;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit e;
        if (!rst_l) begin
            for (int i = 0; i < NT; i++) begin
                m_engaged[i] = 0; m_blockcyc[i] = 0; m_halted[i] = 0;
                m_streak[i] = 0; m_tmo[i] = 0; m_pulse[i] = 0; m_hcnt[i] = 0;
            end
            m_idle = 0;
            return;
        end
        m_idle = 1;
        for (int i = 0; i < NT; i++) begin
            e = stbuf_empty[i] && bbuf_empty[i] && bus_idle[i] && !pipe_busy[i];
            if (e == 0 || lr_vld[i]) m_idle = 0;
            if (m_halted[i] && m_hcnt[i] < 65535) m_hcnt[i]++;
            m_pulse[i] = 0;
            if (force_halt[i]) begin
                m_engaged[i] = 1; m_halted[i] = 1; m_blockcyc[i] = 0;
                m_streak[i] = 0; m_tmo[i] = 0;
            end else if (m_engaged[i] && !halt_req[i]) begin
                m_engaged[i] = 0; m_halted[i] = 0; m_blockcyc[i] = 0;
                m_streak[i] = 0; m_tmo[i] = 0;
            end else if (m_halted[i]) begin
                // stays halted
            end else if (!m_engaged[i]) begin
                if (halt_req[i]) begin
                    m_engaged[i] = 1; m_blockcyc[i] = 1;
                end
            end else if (m_blockcyc[i]) begin
                m_blockcyc[i] = 0;
            end else if (m_streak[i] == 0) begin
                if (m_tmo[i] < TMAX) begin
                    m_tmo[i]++;
                    m_pulse[i] = (m_tmo[i] == TMAX);
                end
                if (e) m_streak[i] = 1;
            end else if (!e) begin
                m_streak[i] = 0;
            end else if (m_streak[i] == QC) begin
                m_halted[i] = 1; m_streak[i] = 0; m_tmo[i] = 0;
            end else begin
                m_streak[i]++;
            end
        end
    endtask

    task automatic check_all();
        logic [NT-1:0]    eb, ea, et;
        logic [NT*16-1:0] eh;
        eh = '0;
        for (int i = 0; i < NT; i++) begin
            eb[i] = m_engaged[i];
            ea[i] = m_halted[i];
            et[i] = m_pulse[i];
`ifdef RV_LSU_QUIESCE_STATS_EN
            eh[16*i +: 16] = 16'(m_hcnt[i]);
`endif
        end
        chk("issue_block", 64'(issue_block), 64'(eb));
        chk("halt_ack", 64'(halt_ack), 64'(ea));
        chk("drain_timeout", 64'(drain_timeout), 64'(et));
        chk("lsu_idle_any", 64'(lsu_idle_any), 64'(m_idle));
        chk("halt_cycles", 64'(halt_cycles), 64'(eh));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    int pulses, pulse_at;

    initial begin
        rst_l = 1'b0; halt_req = '0; force_halt = '0; pipe_busy = '0;
        stbuf_empty = '1; bbuf_empty = '1; bus_idle = '1; lr_vld = '0;
        tick(); tick();
        chk("reset_ack", 64'(halt_ack), 64'd0);
        rst_l = 1'b1;
        tick();

        // Basic halt: block at +1, ack at +7, thread 1 untouched
        halt_req[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t1_block0", 64'(issue_block[0]), 64'(k >= 1));
            chk("t1_ack0", 64'(halt_ack[0]), 64'(k >= 7));
            chk("t1_thread1", 64'({issue_block[1], halt_ack[1], drain_timeout[1]}), 64'd0);
        end
        for (int k = 0; k < 98; k++) tick();
        release_both();

        // QUIET interrupted by a one-cycle pipe_busy pulse
        halt_req[0] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        pipe_busy[0] = 1'b1;
        tick();
        chk("t2_back_to_drain", 64'(halt_ack[0]), 64'd0);
        pipe_busy[0] = 1'b0;
        for (int k = 0; k < 30 && !halt_ack[0]; k++) tick();
        chk("t2_ack_seen", 64'(halt_ack[0]), 64'd1);
        release_both();

        // Drain timeout on thread 1: single pulse 15 cycles after DRAIN entry
        bus_idle[1] = 1'b0;
        halt_req[1] = 1'b1;
        pulses = 0; pulse_at = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (drain_timeout[1]) begin
                pulses++;
                pulse_at = k;
            end
        end
        chk("t3_pulse_count", 64'(pulses), 64'd1);
        chk("t3_pulse_cycle", 64'(pulse_at), 64'd17);
        chk("t3_still_draining", 64'({issue_block[1], halt_ack[1]}), 64'b10);
        bus_idle[1] = 1'b1;
        release_both();

        // Force halt bypasses drain; force outranks release
        stbuf_empty[1] = 1'b0;
        force_halt[1] = 1'b1; halt_req[1] = 1'b1;
        tick();
        chk("t4_forced_ack", 64'(halt_ack[1]), 64'd1);
        halt_req[1] = 1'b0;
        tick();
        chk("t4_force_beats_release", 64'(halt_ack[1]), 64'd1);
        force_halt[1] = 1'b0;
        tick();
        chk("t4_released", 64'({issue_block[1], halt_ack[1]}), 64'd0);
        stbuf_empty[1] = 1'b1;
        tick();

        // Reset while thread 0 halted and thread 1 draining
        halt_req = '1; bus_idle[1] = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst_l = 1'b0;
        tick();
        chk("t5_reset_outputs", 64'({issue_block, halt_ack, drain_timeout, lsu_idle_any}), 64'd0);
        rst_l = 1'b1; bus_idle[1] = 1'b1;
        tick();
        chk("t5_reblock", 64'(issue_block[0]), 64'd1);
        release_both();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NT; i++) begin
                if ($urandom_range(19, 0) == 0) halt_req[i] = ~halt_req[i];
                if (force_halt[i]) force_halt[i] = ($urandom_range(3, 0) != 0);
                else force_halt[i] = ($urandom_range(79, 0) == 0);
                pipe_busy[i]   = ($urandom_range(5, 0) == 0);
                stbuf_empty[i] = ($urandom_range(7, 0) != 0);
                bbuf_empty[i]  = ($urandom_range(9, 0) != 0);
                bus_idle[i]    = ($urandom_range(9, 0) != 0);
                lr_vld[i]      = ($urandom_range(3, 0) == 0);
            end
            rst_l = ($urandom_range(499, 0) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic release_both();
        halt_req = '0; force_halt = '0;
        tick();
        chk("release_outputs", 64'({issue_block, halt_ack}), 64'd0);
        tick();
    endtask

endmodule
